rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader: receives a framed byte stream (word count, payload, checksum)
// and writes the payload into a word-addressed memory, holding the core in
// reset until a complete image with a correct checksum has been loaded.
// Optional feature macro: LOADER_VERIFY_EN adds a read-back check of every
// written word; without it r_addr_o is tied to zero and r_data_i is unused.
module rom_loader #(
   parameter int unsigned ROM_DEPTH_BIT_LEN = 12,
   parameter logic [31:0] BASE_ADDR         = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        w_en_o,
   output logic [31:0] w_addr_o,
   output logic [31:0] w_data_o,
   output logic [3:0]  w_sel_o,
   output logic [31:0] r_addr_o,
   input  logic [31:0] r_data_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        cpu_hold_o
);

   localparam int unsigned IDX_W     = ROM_DEPTH_BIT_LEN + 1;
   localparam logic [32:0] ROM_WORDS = 33'(1) << ROM_DEPTH_BIT_LEN;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_WRITE,
`ifdef LOADER_VERIFY_EN
      S_VERIFY,
`endif
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;

   state_e             state_q;
   logic [1:0]         cnt_q;
   logic [31:0]        len_q;
   logic [31:0]        word_q;
   logic [7:0]         sum_q;
   logic [IDX_W-1:0]   idx_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;
   logic               err_q;
   logic               hold_q;
   logic               w_en_q;
   logic [3:0]         w_sel_q;
   logic [31:0]        w_addr_q;
   logic [31:0]        w_data_q;

   logic               byte_fire;
   logic [31:0]        len_d;
   logic [31:0]        word_d;
   logic [IDX_W-1:0]   idx_d;
   logic               idx_last_d;
   logic [31:0]        wr_addr_d;

   // Handshake and values completed by the byte currently on the bus.
   always_comb begin
      byte_fire  = byte_valid_i & ready_q;
      len_d      = {byte_data_i, len_q[23:0]};
      word_d     = {byte_data_i, word_q[23:0]};
      idx_d      = idx_q + IDX_W'(1);
      idx_last_d = (32'(idx_d) == len_q);
      wr_addr_d  = BASE_ADDR + (32'(idx_q) << 2);
   end

`ifdef LOADER_VERIFY_EN
   logic [31:0] r_addr_q;
   assign r_addr_o = r_addr_q;
`else
   logic unused_r_data;
   assign unused_r_data = ^r_data_i;
   assign r_addr_o      = 32'h0;
`endif

   // Frame-parsing FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 2'd0;
         len_q    <= 32'h0;
         word_q   <= 32'h0;
         sum_q    <= 8'h0;
         idx_q    <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         hold_q   <= 1'b1;
         w_en_q   <= 1'b0;
         w_sel_q  <= 4'h0;
         w_addr_q <= 32'h0;
         w_data_q <= 32'h0;
`ifdef LOADER_VERIFY_EN
         r_addr_q <= 32'h0;
`endif
      end else begin
         w_en_q  <= 1'b0;
         w_sel_q <= 4'h0;
         case (state_q)
            S_IDLE: begin
               if (byte_fire) begin
                  len_q   <= {24'h0, byte_data_i};
                  cnt_q   <= 2'd1;
                  sum_q   <= 8'h0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_LEN;
               end
            end
            S_LEN: begin
               if (byte_fire) begin
                  len_q[{cnt_q, 3'b000} +: 8] <= byte_data_i;
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     if (len_d == 32'h0) begin
                        state_q <= S_CSUM;
                     end else if ({1'b0, len_d} > ROM_WORDS) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                     end else begin
                        state_q <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (byte_fire) begin
                  word_q[{cnt_q, 3'b000} +: 8] <= byte_data_i;
                  sum_q <= sum_q + byte_data_i;
                  cnt_q <= cnt_q + 2'd1;
                  if (cnt_q == 2'd3) begin
                     ready_q  <= 1'b0;
                     w_en_q   <= 1'b1;
                     w_sel_q  <= 4'hF;
                     w_addr_q <= wr_addr_d;
                     w_data_q <= word_d;
                     state_q  <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
`ifdef LOADER_VERIFY_EN
               r_addr_q <= w_addr_q;
               state_q  <= S_VERIFY;
`else
               idx_q   <= idx_d;
               ready_q <= 1'b1;
               state_q <= idx_last_d ? S_CSUM : S_DATA;
`endif
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
               if (r_data_i != w_data_q) begin
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  idx_q   <= idx_d;
                  ready_q <= 1'b1;
                  state_q <= idx_last_d ? S_CSUM : S_DATA;
               end
            end
`endif
            S_CSUM: begin
               if (byte_fire) begin
                  ready_q <= 1'b0;
                  busy_q  <= 1'b0;
                  if (byte_data_i == sum_q) begin
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
                     state_q <= S_DONE;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_DONE;
            end
            S_ERR: begin
               state_q <= S_ERR;
            end
            default: begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               err_q   <= 1'b1;
               state_q <= S_ERR;
            end
         endcase
      end
   end

   assign byte_ready_o = ready_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign cpu_hold_o   = hold_q;
   assign w_en_o       = w_en_q;
   assign w_sel_o      = w_sel_q;
   assign w_addr_o     = w_addr_q;
   assign w_data_o     = w_data_q;

endmodule
